// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between instruction-fetch (I) and data (D) requesters.
// Latency: 3 cycles minimum (IDLE -> BUSY -> RESP), plus one per ack wait cycle.
// Backpressure: level requests held until the one-cycle Ready; oStall holds the CPU.
// Optional: define ARB_ROUND_ROBIN_EN to alternate priority under contention.
module mem_bus_arbiter #(
  parameter int          TIMEOUT    = 16,
  parameter logic [31:0] ABORT_DATA = 32'h00000000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iIReq,
  input  logic [31:0] iIAddress,
  output logic [31:0] oIReadData,
  output logic        oIReady,
  input  logic        iDReq,
  input  logic        iDWrite,
  input  logic [3:0]  iDByteEnable,
  input  logic [31:0] iDAddress,
  input  logic [31:0] iDWriteData,
  output logic [31:0] oDReadData,
  output logic        oDReady,
  output logic        oMReq,
  output logic        oMWrite,
  output logic [3:0]  oMByteEnable,
  output logic [31:0] oMAddress,
  output logic [31:0] oMWriteData,
  input  logic [31:0] iMReadData,
  input  logic        iMAck,
  output logic [1:0]  oGrant,
  output logic        oStall,
  output logic        oBusError
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_I    = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [1:0]    grant;
  logic [31:0]   lat_addr;
  logic          lat_write;
  logic [3:0]    lat_be;
  logic [31:0]   lat_wdata;
  logic [31:0]   i_rdata;
  logic [31:0]   d_rdata;
  logic [CW-1:0] wait_cnt;
  logic          err_flag;

  logic          req_any;
  logic          pick_d;
  logic          timeout_hit;
  logic          grant_start;
  logic          done;

  assign req_any = iIReq | iDReq;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 when D was granted most recently; resets to I so D wins the first contention.
  logic last_d;

  // Remember who owned the bus last so contention alternates.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      last_d <= 1'b0;
    end else if (grant_start) begin
      last_d <= pick_d;
    end
  end

  assign pick_d = iDReq & (~iIReq | ~last_d);
`else
  // The data access belongs to an instruction already fetched, so D goes first.
  assign pick_d = iDReq;
`endif

  assign grant_start = (state == IDLE) & req_any;
  // An ack in the same cycle as the final count wins over the abort.
  assign timeout_hit = (state == BUSY) & ~iMAck & (wait_cnt == CNT_LAST);
  assign done        = (state == BUSY) & (iMAck | timeout_hit);

  // State register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection: one transaction at a time, always back through IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req_any) state_nxt = BUSY;
      BUSY:    if (done)    state_nxt = RESP;
      RESP:                 state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Capture the winner's request on grant so later requester changes are ignored.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      grant     <= GRANT_NONE;
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_be    <= '0;
      lat_wdata <= '0;
    end else if (grant_start) begin
      grant     <= pick_d ? GRANT_D : GRANT_I;
      lat_addr  <= pick_d ? iDAddress : iIAddress;
      lat_write <= pick_d & iDWrite;
      lat_be    <= pick_d ? iDByteEnable : 4'b1111;
      lat_wdata <= pick_d ? iDWriteData : 32'h0;
    end else if (state == RESP) begin
      grant     <= GRANT_NONE;
    end
  end

  // Per-requester read data, held until that requester's next completion.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      i_rdata <= '0;
      d_rdata <= '0;
    end else if (done) begin
      if (grant == GRANT_I) begin
        i_rdata <= iMAck ? iMReadData : ABORT_DATA;
      end else begin
        d_rdata <= iMAck ? iMReadData : ABORT_DATA;
      end
    end
  end

  // Wait-state watchdog and the error flag it raises for the response cycle.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wait_cnt <= '0;
      err_flag <= 1'b0;
    end else if (state == RESP) begin
      wait_cnt <= '0;
      err_flag <= 1'b0;
    end else if (timeout_hit) begin
      err_flag <= 1'b1;
    end else if ((state == BUSY) & ~iMAck) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  // Outputs: memory side only while BUSY, Ready/error only in RESP.
  always_comb begin
    oMReq        = 1'b0;
    oMWrite      = 1'b0;
    oMByteEnable = 4'b0000;
    oMAddress    = 32'h0;
    oMWriteData  = 32'h0;
    oIReady      = 1'b0;
    oDReady      = 1'b0;
    oBusError    = 1'b0;
    if (state == BUSY) begin
      oMReq        = 1'b1;
      oMWrite      = lat_write;
      oMByteEnable = lat_be;
      oMAddress    = lat_addr;
      oMWriteData  = lat_wdata;
    end
    if (state == RESP) begin
      oIReady   = (grant == GRANT_I);
      oDReady   = (grant == GRANT_D);
      oBusError = err_flag;
    end
    oStall = (iIReq & ~oIReady) | (iDReq & ~oDReady);
  end

  assign oIReadData = i_rdata;
  assign oDReadData = d_rdata;
  assign oGrant     = grant;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level model compared every cycle,
// plus hand-computed checks for latency, data, ordering and watchdog.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  localparam int          TO    = 16;
  localparam logic [31:0] ABORT = 32'h00000000;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iIReq;
  logic [31:0] iIAddress;
  logic [31:0] oIReadData;
  logic        oIReady;
  logic        iDReq;
  logic        iDWrite;
  logic [3:0]  iDByteEnable;
  logic [31:0] iDAddress;
  logic [31:0] iDWriteData;
  logic [31:0] oDReadData;
  logic        oDReady;
  logic        oMReq;
  logic        oMWrite;
  logic [3:0]  oMByteEnable;
  logic [31:0] oMAddress;
  logic [31:0] oMWriteData;
  logic [31:0] iMReadData;
  logic        iMAck;
  logic [1:0]  oGrant;
  logic        oStall;
  logic        oBusError;

  mem_bus_arbiter #(.TIMEOUT(TO), .ABORT_DATA(ABORT)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iIReq(iIReq), .iIAddress(iIAddress), .oIReadData(oIReadData), .oIReady(oIReady),
    .iDReq(iDReq), .iDWrite(iDWrite), .iDByteEnable(iDByteEnable), .iDAddress(iDAddress),
    .iDWriteData(iDWriteData), .oDReadData(oDReadData), .oDReady(oDReady),
    .oMReq(oMReq), .oMWrite(oMWrite), .oMByteEnable(oMByteEnable), .oMAddress(oMAddress),
    .oMWriteData(oMWriteData), .iMReadData(iMReadData), .iMAck(iMAck),
    .oGrant(oGrant), .oStall(oStall), .oBusError(oBusError)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory slave ----------------
  int          ack_wait = -1;   // BUSY cycles before ack; -1 = never acknowledge
  int          seen = 0;
  bit          stray = 1'b0;
  logic [31:0] slv_data = 32'h0;

  initial begin
    iMAck = 1'b0;
    iMReadData = 32'h0;
    forever begin
      @(posedge iCLK);
      #1;
      if (stray) begin
        iMAck = 1'b1;
      end else if (oMReq === 1'b1) begin
        iMAck = (ack_wait >= 0) && (seen == ack_wait);
        seen++;
      end else begin
        iMAck = 1'b0;
        seen = 0;
      end
      iMReadData = slv_data;
    end
  end

  // ---------------- transaction-level model ----------------
  int          m_owner;         // 0 none, 1 instruction, 2 data
  int          m_age;           // BUSY cycles already spent waiting
  bit          m_done;          // in the completion cycle
  bit          m_err;
  bit          m_last_d;
  logic        m_wr;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wd, m_ird, m_drd;

  function automatic bit d_wins(input logic i_req, input logic d_req, input bit last_d);
`ifdef ARB_ROUND_ROBIN_EN
    return d_req && (!i_req || !last_d);
`else
    return d_req;
`endif
  endfunction

  always @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      m_owner <= 0; m_age <= 0; m_done <= 1'b0; m_err <= 1'b0; m_last_d <= 1'b0;
      m_wr <= 1'b0; m_be <= '0; m_addr <= '0; m_wd <= '0; m_ird <= '0; m_drd <= '0;
    end else if (m_done) begin
      m_done <= 1'b0; m_owner <= 0; m_err <= 1'b0;
    end else if (m_owner != 0) begin
      if (iMAck) begin
        if (m_owner == 1) m_ird <= iMReadData; else m_drd <= iMReadData;
        m_done <= 1'b1;
      end else if (m_age + 1 == TO) begin
        if (m_owner == 1) m_ird <= ABORT; else m_drd <= ABORT;
        m_err <= 1'b1;
        m_done <= 1'b1;
      end else begin
        m_age <= m_age + 1;
      end
    end else if (iIReq || iDReq) begin
      m_owner  <= d_wins(iIReq, iDReq, m_last_d) ? 2 : 1;
      m_last_d <= d_wins(iIReq, iDReq, m_last_d);
      m_age    <= 0;
      m_wr     <= d_wins(iIReq, iDReq, m_last_d) ? iDWrite : 1'b0;
      m_be     <= d_wins(iIReq, iDReq, m_last_d) ? iDByteEnable : 4'b1111;
      m_addr   <= d_wins(iIReq, iDReq, m_last_d) ? iDAddress : iIAddress;
      m_wd     <= d_wins(iIReq, iDReq, m_last_d) ? iDWriteData : 32'h0;
    end
  end

  logic        e_busy, e_irdy, e_drdy, e_berr, e_stall;
  logic [1:0]  e_grant;

  always_comb begin
    e_busy  = (m_owner != 0) && !m_done;
    e_grant = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    e_irdy  = m_done && (m_owner == 1);
    e_drdy  = m_done && (m_owner == 2);
    e_berr  = m_done && m_err;
    e_stall = (iIReq & ~e_irdy) | (iDReq & ~e_drdy);
  end

  // ---------------- per-cycle compare and event log ----------------
  int mreq_total = 0;
  int irdy_total = 0;
  int drdy_total = 0;
  int order_q[$];

  always @(negedge iCLK) begin
    check("mreq",   oMReq,        e_busy);
    check("mwrite", oMWrite,      e_busy ? m_wr : 1'b0);
    check("mbe",    oMByteEnable, e_busy ? m_be : 4'b0000);
    check("maddr",  oMAddress,    e_busy ? m_addr : 32'h0);
    check("mwdata", oMWriteData,  e_busy ? m_wd : 32'h0);
    check("grant",  oGrant,       e_grant);
    check("iready", oIReady,      e_irdy);
    check("dready", oDReady,      e_drdy);
    check("berr",   oBusError,    e_berr);
    check("irdata", oIReadData,   m_ird);
    check("drdata", oDReadData,   m_drd);
    check("stall",  oStall,       e_stall);
    if (oMReq === 1'b1) mreq_total++;
    if (oIReady === 1'b1) begin irdy_total++; order_q.push_back(1); end
    if (oDReady === 1'b1) begin drdy_total++; order_q.push_back(2); end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_ready(input bit want_d, input int budget, output int at);
    at = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge iCLK);
      if ((want_d ? oDReady : oIReady) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL ready_wait actual=none required=%s within %0d cycles", want_d ? "D" : "I", budget);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  int req_at, rdy_at, rdy2_at, snap_m, snap_i, snap_d, snap_o;
  int exp_first;

  initial begin
    iRST = 1'b1;
    iIReq = 1'b0; iIAddress = '0;
    iDReq = 1'b0; iDWrite = 1'b0; iDByteEnable = '0; iDAddress = '0; iDWriteData = '0;
    repeat (2) step();
    check("rst_mreq",  oMReq,      1'b0);
    check("rst_grant", oGrant,     2'b00);
    check("rst_irdat", oIReadData, 32'h0);
    check("rst_stall", oStall,     1'b0);
    iRST = 1'b0;
    step();

    // Fetch with two wait states.
    ack_wait = 2; slv_data = 32'h00500513;
    iIReq = 1'b1; iIAddress = 32'h00400000; req_at = cyc;
    #1 check("fetch_stall_req", oStall, 1'b1);
    step();
    check("fetch_maddr", oMAddress,    32'h00400000);
    check("fetch_mbe",   oMByteEnable, 4'b1111);
    check("fetch_mwr",   oMWrite,      1'b0);
    wait_ready(1'b0, 20, rdy_at);
    check("fetch_latency", rdy_at - req_at, 4);
    check("fetch_rdata",   oIReadData,      32'h00500513);
    #1 iIReq = 1'b0;
    @(negedge iCLK);
    check("fetch_stall_after", oStall, 1'b0);

    // Contention from priority state "last = I": D first in both modes.
    ack_wait = 1; slv_data = 32'h11112222;
    step();
    snap_o = order_q.size(); snap_i = irdy_total; snap_d = drdy_total;
    iIReq = 1'b1; iIAddress = 32'h00400004;
    iDReq = 1'b1; iDWrite = 1'b0; iDByteEnable = 4'b1111; iDAddress = 32'h10010000;
    wait_ready(1'b1, 20, rdy_at);
    #1 iDReq = 1'b0;
    wait_ready(1'b0, 20, rdy2_at);
    #1 iIReq = 1'b0;
    repeat (3) @(negedge iCLK);
    check("cont1_first",  order_q[snap_o],     2);
    check("cont1_second", order_q[snap_o + 1], 1);
    check("cont1_i_once", irdy_total - snap_i, 1);
    check("cont1_d_once", drdy_total - snap_d, 1);

    // Store with immediate ack.
    ack_wait = 0; slv_data = 32'h0BADF00D;
    step();
    iDReq = 1'b1; iDWrite = 1'b1; iDAddress = 32'h10010004;
    iDByteEnable = 4'b0011; iDWriteData = 32'h0000BEEF; req_at = cyc;
    step();
    check("store_mwr",   oMWrite,      1'b1);
    check("store_mbe",   oMByteEnable, 4'b0011);
    check("store_maddr", oMAddress,    32'h10010004);
    check("store_wdata", oMWriteData,  32'h0000BEEF);
    wait_ready(1'b1, 20, rdy_at);
    check("store_latency", rdy_at - req_at, 2);
    #1 iDReq = 1'b0; iDWrite = 1'b0;

    // Contention after a D grant: round robin serves I first.
`ifdef ARB_ROUND_ROBIN_EN
    exp_first = 1;
`else
    exp_first = 2;
`endif
    step();
    snap_o = order_q.size();
    iIReq = 1'b1; iDReq = 1'b1; iDByteEnable = 4'b1111;
    wait_ready(exp_first == 2, 20, rdy_at);
    #1 if (exp_first == 2) iDReq = 1'b0; else iIReq = 1'b0;
    wait_ready(exp_first != 2, 20, rdy2_at);
    #1 begin iIReq = 1'b0; iDReq = 1'b0; end
    repeat (2) @(negedge iCLK);
    check("cont2_first", order_q[snap_o], exp_first);

    // Watchdog: slave never answers.
    ack_wait = -1;
    step();
    snap_m = mreq_total;
    iDReq = 1'b1; iDAddress = 32'h10020000;
    wait_ready(1'b1, 40, rdy_at);
    check("to_berr",  oBusError, 1'b1);
    check("to_rdata", oDReadData, 32'h00000000);
    check("to_mreq_cycles", mreq_total - snap_m, 16);
    #1 iDReq = 1'b0;
    @(negedge iCLK);
    check("to_berr_clear", oBusError, 1'b0);

    // Ack on the final watchdog cycle wins.
    ack_wait = TO - 1; slv_data = 32'hCAFEF00D;
    step();
    iDReq = 1'b1; req_at = cyc;
    wait_ready(1'b1, 40, rdy_at);
    check("edge_berr",    oBusError,       1'b0);
    check("edge_rdata",   oDReadData,      32'hCAFEF00D);
    check("edge_latency", rdy_at - req_at, 17);
    #1 iDReq = 1'b0;

    // Stray ack while idle.
    step();
    snap_i = irdy_total; snap_d = drdy_total;
    @(negedge iCLK); stray = 1'b1;
    @(negedge iCLK); stray = 1'b0;
    repeat (3) @(negedge iCLK);
    check("stray_grant", oGrant, 2'b00);
    check("stray_rdy",   (irdy_total - snap_i) + (drdy_total - snap_d), 0);

    // Reset in the middle of a hung transaction, requests held across it.
    ack_wait = -1; slv_data = 32'h5A5A5A5A;
    step();
    iIReq = 1'b1; iDReq = 1'b1; iDAddress = 32'h10030000;
    repeat (3) step();
    #2 iRST = 1'b1;
    #1;
    check("mid_rst_mreq",  oMReq,      1'b0);
    check("mid_rst_grant", oGrant,     2'b00);
    check("mid_rst_drdat", oDReadData, 32'h0);
    check("mid_rst_maddr", oMAddress,  32'h0);
    ack_wait = 0;
    step();
    iRST = 1'b0;
    wait_ready(1'b1, 20, rdy_at);
    check("after_rst_drdata", oDReadData, 32'h5A5A5A5A);
    #1 iDReq = 1'b0;
    wait_ready(1'b0, 20, rdy2_at);
    #1 iIReq = 1'b0;
    repeat (3) @(negedge iCLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
